// File: rtl/seg_pattern_encoder_pkg.sv
// Shared constants and types for the 7-segment pattern encoder.
// Patterns are active-low, bit 6 = a ... bit 0 = g.
package seg_pattern_encoder_pkg;

   localparam logic [6:0] SEG_0     = 7'h01;
   localparam logic [6:0] SEG_1     = 7'h4F;
   localparam logic [6:0] SEG_2     = 7'h12;
   localparam logic [6:0] SEG_3     = 7'h06;
   localparam logic [6:0] SEG_4     = 7'h4C;
   localparam logic [6:0] SEG_5     = 7'h24;
   localparam logic [6:0] SEG_6     = 7'h20;
   localparam logic [6:0] SEG_7     = 7'h0F;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h04;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_DIGITS [10] = '{
      SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
      SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_LOCKED
   } state_e;

   typedef struct packed {
      logic       legal;
      logic       blank;
      logic [3:0] digit;
   } lut_out_t;

endpackage

// File: rtl/seg_pattern_lut.sv
// Combinational reverse lookup: segment pattern to BCD digit.
// Anything neither a digit nor blank comes out with legal=0, blank=0.
module seg_pattern_lut
   import seg_pattern_encoder_pkg::*;
(
   input  logic [6:0] pat,
   output lut_out_t   res
);

   always_comb begin
      res.legal = 1'b0;
      res.blank = (pat == SEG_BLANK);
      res.digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (pat == SEG_DIGITS[i]) begin
            res.legal = 1'b1;
            res.digit = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg_pattern_encoder.sv
// Recovers BCD digits from a 7-segment bus once a pattern has settled,
// reporting each new stable pattern once over a valid/ready handshake.
module seg_pattern_encoder
   import seg_pattern_encoder_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           seg,
   input  logic                 dig_ready,
   output logic [3:0]           digit,
   output logic                 dig_valid,
   output logic                 err,
   output logic                 overrun,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

   logic [6:0]           samp_q, samp_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [6:0]           last_q, last_d;
   state_e               state_q, state_d;
   logic [3:0]           digit_q, digit_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic                 ovr_q, ovr_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic     accept;
   lut_out_t lut;

   seg_pattern_lut u_lut (
      .pat (samp_q),
      .res (lut)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (samp_q != last_q) state_d = ST_SETTLE;
         ST_SETTLE: if (cnt_q == STABLE_MAX) state_d = ST_LOCKED;
         ST_LOCKED: if (samp_q != last_q) state_d = ST_SETTLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      accept = (state_q == ST_SETTLE) && (cnt_q == STABLE_MAX);
      last_d = accept ? samp_q : last_q;
   end

   // cnt_q measures how long samp_q itself has been unchanged
   always_comb begin
      samp_d = seg;
      if (seg != samp_q) begin
         cnt_d = 8'd0;
      end else if (cnt_q == STABLE_MAX) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_comb begin
      digit_d   = digit_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      if (accept && lut.legal) begin
         if (!valid_q || dig_ready) begin
            digit_d = lut.digit;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && dig_ready) begin
         valid_d = 1'b0;
      end
      if (accept && !lut.legal && !lut.blank) begin
         err_d = 1'b1;
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_q    <= SEG_BLANK;
         cnt_q     <= 8'd0;
         last_q    <= SEG_BLANK;
         digit_q   <= 4'd0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         ovr_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         samp_q    <= samp_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         digit_q   <= digit_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         ovr_q     <= ovr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign digit     = digit_q;
   assign dig_valid = valid_q;
   assign err       = err_q;
   assign overrun   = ovr_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seg_pattern_encoder.sv
// Randomized and directed bench for seg_pattern_encoder against a
// run-length based reference model.
module tb_seg_pattern_encoder;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] seg = 7'h7F;
   logic       dig_ready = 1'b0;
   logic [3:0] digit;
   logic       dig_valid;
   logic       err;
   logic       overrun;
   logic [7:0] err_cnt;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] REF_PAT [10] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
      7'h24, 7'h20, 7'h0F, 7'h00, 7'h04
   };

   seg_pattern_encoder #(.STABLE_CYCLES(S), .ERR_CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg       (seg),
      .dig_ready (dig_ready),
      .digit     (digit),
      .dig_valid (dig_valid),
      .err       (err),
      .overrun   (overrun),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // model: run = number of consecutive samples equal to m_samp
   logic [6:0] m_samp, m_last;
   int         m_run;
   bit         m_armed;
   logic [3:0] m_digit;
   logic       m_valid, m_err, m_ovr;
   logic [7:0] m_ecnt;

   function automatic int decode(input logic [6:0] p);
      if (p == 7'h7F) return 10;
      for (int i = 0; i < 10; i++) if (REF_PAT[i] == p) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_samp = 7'h7F; m_last = 7'h7F; m_run = 1; m_armed = 0;
      m_digit = 0; m_valid = 0; m_err = 0; m_ovr = 0; m_ecnt = 0;
   endtask

   task automatic model_step();
      bit acc;
      int d;
      acc = m_armed && (m_run >= S + 1);
      d = decode(m_samp);
      m_err = 0;
      if (acc && d >= 0 && d < 10) begin
         if (!m_valid || dig_ready) begin
            m_digit = 4'(d);
            m_valid = 1;
         end else begin
            m_ovr = 1;
         end
      end else if (m_valid && dig_ready) begin
         m_valid = 0;
      end
      if (acc && d < 0) begin
         m_err = 1;
         if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
      end
      m_armed = acc ? 1'b0 : (m_armed || (m_samp != m_last));
      if (acc) m_last = m_samp;
      m_run = (seg == m_samp) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
      m_samp = seg;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      seg = 7'h7F;
      #1 rst = 1'b1;
      model_reset();
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({digit, dig_valid, err, overrun, err_cnt} !== 15'd0) begin
         errors++;
         $display("FAIL reset: got %h/%b/%b/%b/%h, want all zero",
                  digit, dig_valid, err, overrun, err_cnt);
      end
   endtask

   task automatic test_all_digits();
      int lat, pulses;
      logic [3:0] seen;
      do_reset();
      dig_ready = 1'b1;
      for (int d = 0; d < 10; d++) begin
         seg = REF_PAT[d];
         lat = -1; pulses = 0; seen = 4'hF;
         for (int k = 1; k <= S + 2; k++) begin
            tick();
            checks++;
            if ({digit, dig_valid, err, overrun, err_cnt} !==
                {m_digit, m_valid, m_err, m_ovr, m_ecnt}) begin
               errors++;
               $display("FAIL digits_model d=%0d: got %h/%b/%b/%b/%h want %h/%b/%b/%b/%h",
                        d, digit, dig_valid, err, overrun, err_cnt,
                        m_digit, m_valid, m_err, m_ovr, m_ecnt);
            end
            if (dig_valid) begin
               pulses++;
               seen = digit;
               if (lat < 0) lat = k - 1;
            end
         end
         checks++;
         if (pulses != 1 || seen !== 4'(d) || lat != S + 1) begin
            errors++;
            $display("FAIL digit_%0d: pulses=%0d digit=%h latency=%0d, want 1/%h/%0d",
                     d, pulses, seen, lat, d, S + 1);
         end
      end
      tick();
   endtask

   task automatic test_glitch();
      int pulses;
      do_reset();
      dig_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         seg = (i % 2 == 0) ? 7'h4F : 7'h12;
         for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (dig_valid !== 1'b0 || err !== 1'b0) begin
               errors++;
               $display("FAIL glitch_quiet: valid=%b err=%b, want 0/0",
                        dig_valid, err);
            end
         end
      end
      seg = 7'h12;
      pulses = 0;
      for (int k = 0; k < S + 4; k++) begin
         tick();
         if (dig_valid) begin
            pulses++;
            checks++;
            if (digit !== 4'd2) begin
               errors++;
               $display("FAIL glitch_digit: got %h want 2", digit);
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL glitch_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_illegal_blank();
      int pulses;
      do_reset();
      dig_ready = 1'b1;
      seg = 7'h7E;
      pulses = 0;
      for (int k = 0; k < S + 3; k++) begin
         tick();
         if (err) pulses++;
      end
      checks++;
      if (pulses != 1 || err_cnt !== 8'd1 || dig_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal: pulses=%0d err_cnt=%0d valid=%b, want 1/1/0",
                  pulses, err_cnt, dig_valid);
      end
      seg = 7'h7F;
      pulses = 0;
      for (int k = 0; k < S + 3; k++) begin
         tick();
         if (err || dig_valid) pulses++;
      end
      checks++;
      if (pulses != 0 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL blank: events=%0d err_cnt=%0d, want 0/1",
                  pulses, err_cnt);
      end
      pulses = 0;
      for (int i = 0; i < 256; i++) begin
         seg = (i % 2 == 0) ? 7'h7D : 7'h7E;
         for (int k = 0; k < S + 2; k++) begin
            tick();
            if (err) pulses++;
            checks++;
            if ({err, err_cnt, dig_valid} !== {m_err, m_ecnt, m_valid}) begin
               errors++;
               $display("FAIL sat_model: got %b/%h/%b want %b/%h/%b",
                        err, err_cnt, dig_valid, m_err, m_ecnt, m_valid);
            end
         end
      end
      tick();
      checks++;
      if (pulses != 256 || err_cnt !== 8'hFF) begin
         errors++;
         $display("FAIL saturate: pulses=%0d err_cnt=%0d, want 256/255",
                  pulses, err_cnt);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      dig_ready = 1'b0;
      seg = REF_PAT[3];
      repeat (S + 2) tick();
      seg = REF_PAT[5];
      repeat (S + 3) tick();
      checks++;
      if (digit !== 4'd3 || dig_valid !== 1'b1 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL backpressure: digit=%h valid=%b ovr=%b, want 3/1/1",
                  digit, dig_valid, overrun);
      end
      dig_ready = 1'b1;
      tick();
      checks++;
      if (dig_valid !== 1'b0 || digit !== 4'd3) begin
         errors++;
         $display("FAIL bp_handshake: valid=%b digit=%h, want 0/3",
                  dig_valid, digit);
      end
      repeat (3) tick();
      checks++;
      if (dig_valid !== 1'b0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL bp_after: valid=%b ovr=%b, want 0/1",
                  dig_valid, overrun);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      dig_ready = 1'b0;
      seg = REF_PAT[7];
      repeat (S + 2) tick();
      checks++;
      if (digit !== 4'd7 || dig_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: digit=%h valid=%b, want 7/1",
                  digit, dig_valid);
      end
      seg = REF_PAT[8];
      repeat (S + 1) tick();
      dig_ready = 1'b1;
      tick();
      checks++;
      if (digit !== 4'd8 || dig_valid !== 1'b1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b: digit=%h valid=%b ovr=%b, want 8/1/0",
                  digit, dig_valid, overrun);
      end
      tick();
      checks++;
      if (dig_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: valid=%b want 0", dig_valid);
      end
   endtask

   task automatic test_async_reset();
      int lat;
      do_reset();
      dig_ready = 1'b0;
      seg = 7'h7E;
      repeat (S + 2) tick();
      seg = REF_PAT[1];
      repeat (S + 2) tick();
      seg = REF_PAT[3];
      repeat (S + 2) tick();
      seg = REF_PAT[6];
      repeat (2) tick();
      seg = 7'h00;
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({digit, dig_valid, err, overrun, err_cnt} !== 15'd0) begin
         errors++;
         $display("FAIL async_reset: got %h/%b/%b/%b/%h, want all zero",
                  digit, dig_valid, err, overrun, err_cnt);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      dig_ready = 1'b1;
      lat = -1;
      for (int k = 1; k <= S + 4 && lat < 0; k++) begin
         tick();
         if (dig_valid) begin
            lat = k - 1;
            checks++;
            if (digit !== 4'd8) begin
               errors++;
               $display("FAIL async_digit: got %h want 8", digit);
            end
         end
      end
      checks++;
      if (lat != S + 1) begin
         errors++;
         $display("FAIL async_latency: got %0d want %0d", lat, S + 1);
      end
   endtask

   task automatic test_random();
      logic [6:0] pool [14];
      int hold;
      for (int i = 0; i < 10; i++) pool[i] = REF_PAT[i];
      pool[10] = 7'h7F; pool[11] = 7'h7E;
      pool[12] = 7'h5A; pool[13] = 7'h3C;
      do_reset();
      for (int n = 0; n < 120; n++) begin
         seg = pool[$urandom_range(0, 13)];
         hold = $urandom_range(1, S + 3);
         for (int k = 0; k < hold; k++) begin
            dig_ready = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if ({digit, dig_valid, err, overrun, err_cnt} !==
                {m_digit, m_valid, m_err, m_ovr, m_ecnt}) begin
               errors++;
               $display("FAIL random: got %h/%b/%b/%b/%h want %h/%b/%b/%b/%h",
                        digit, dig_valid, err, overrun, err_cnt,
                        m_digit, m_valid, m_err, m_ovr, m_ecnt);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_all_digits();
      test_glitch();
      test_illegal_blank();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
